// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller:
//   - state_e       : controller FSM state encoding
//   - BE_*          : the byte-lane masks the controller accepts
//   - MTIME_*_OFS   : word offsets of the mtime halves inside the mtime window
//                     (only used when DMEM_MTIME_EN is defined)
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_READ   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  localparam logic [31:0] MTIME_LO_OFS = 32'd0;
  localparam logic [31:0] MTIME_HI_OFS = 32'd4;

endpackage

// File: rtl/dmem_be_check.sv
// -----------------------------------------------------------------------------
// dmem_be_check
// Combinational legality check of one load/store request.
//   byte_en : lane mask of the request
//   addr    : byte address of the request
//   legal   : 1 when the mask is supported, addr[1:0] points at the lowest
//             enabled lane, and addr lies inside the SRAM window
// -----------------------------------------------------------------------------
module dmem_be_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 1024
) (
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  output logic        legal
);

  // One bit wider so BASE_ADDR + 4*DEPTH cannot wrap at the top of the map.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  logic align_ok;
  logic range_ok;

  always_comb begin
    align_ok = 1'b0;
    case (byte_en)
      BE_B0, BE_HLO, BE_W: align_ok = (addr[1:0] == 2'd0);
      BE_B1:               align_ok = (addr[1:0] == 2'd1);
      BE_B2, BE_HHI:       align_ok = (addr[1:0] == 2'd2);
      BE_B3:               align_ok = (addr[1:0] == 2'd3);
      default:             align_ok = 1'b0;
    endcase
  end

  assign range_ok = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);
  assign legal    = align_ok && range_ok;

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller between the core load/store port and a synchronous
// single-port SRAM with one-cycle read latency.
//   core side : sel, we, byte_en, addr, din in; dout, ack, err out
//   SRAM side : ram_ce, ram_we, ram_be, ram_addr, ram_wdata out; ram_rdata in
// Handshake: the master raises sel with all request fields and holds them
// until ack; ack is a single-cycle pulse (err qualifies it). A request is only
// sampled in IDLE, so fields are latched there and ignored afterwards; a
// dropped sel does not cancel a request already accepted.
// Optional build macro DMEM_MTIME_EN adds a 64-bit free-running mtime counter
// readable as two words at MTIME_ADDR / MTIME_ADDR+4.
// -----------------------------------------------------------------------------
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 1024,
  parameter int          AW          = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] MTIME_ADDR  = 32'h0000_0F00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic          we,
  input  logic [3:0]    byte_en,
  input  logic [31:0]   addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          ack,
  output logic          err,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     dout_q, dout_d;

  logic            legal;
  logic [31:0]     off;
  logic            unused_off_bits;
  logic            access;

  // mtime window decode: win_hit = address falls in the 8-byte window,
  // win_ok = it is a supported word load of one of the two halves.
  logic            win_hit;
  logic            win_ok;
  logic [31:0]     mtime_word;

  dmem_be_check #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_be_check (
    .byte_en (byte_en),
    .addr    (addr),
    .legal   (legal)
  );

  // Word index inside the SRAM; only meaningful once the range check passed.
  assign off             = addr - BASE_ADDR;
  assign unused_off_bits = ^{off[31:AW+2], off[1:0]};

`ifdef DMEM_MTIME_EN
  logic [63:0] mtime_q, mtime_d;
  logic        win_hi;

  assign mtime_d    = mtime_q + 64'd1;
  // Unsigned wrap makes addresses below MTIME_ADDR fall outside the window.
  assign win_hit    = (addr - MTIME_ADDR) < 32'd8;
  assign win_hi     = (addr == MTIME_ADDR + MTIME_HI_OFS);
  assign win_ok     = !we && (byte_en == BE_W) &&
                      ((addr == MTIME_ADDR + MTIME_LO_OFS) || win_hi);
  assign mtime_word = win_hi ? mtime_q[63:32] : mtime_q[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mtime_q <= '0;
    else        mtime_q <= mtime_d;
  end
`else
  localparam logic [31:0] unused_mtime_addr = MTIME_ADDR;

  assign win_hit    = 1'b0;
  assign win_ok     = 1'b0;
  assign mtime_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    dout_d  = dout_q;

    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          we_d    = we;
          be_d    = byte_en;
          widx_d  = off[AW+1:2];
          wdata_d = din;
          err_d   = 1'b0;
          if (win_hit) begin
            // mtime reads bypass wait states and the SRAM entirely.
            err_d   = !win_ok;
            if (win_ok) dout_d = mtime_word;
            state_d = ST_RESP;
          end else if (!legal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (WAIT_STATES > 0) begin
            cnt_d   = WS_INIT;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = we_q ? ST_RESP : ST_READ;
      ST_READ: begin
        dout_d  = ram_rdata;
        state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // All SRAM-facing outputs are forced to zero outside ACCESS so the macro
  // only ever sees a single-cycle, fully qualified access.
  assign access    = (state_q == ST_ACCESS);
  assign ram_ce    = access;
  assign ram_we    = access && we_q;
  assign ram_be    = (access && we_q) ? be_q : 4'b0000;
  assign ram_addr  = access ? widx_q : '0;
  assign ram_wdata = access ? wdata_q : '0;

  assign ack  = (state_q == ST_RESP);
  assign err  = ack && err_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Two controller instances share clock and reset: index 0 has no wait states,
// index 1 has three. Each drives its own behavioural SRAM. Expected responses
// come from a fixed vector table and from a transaction-level reference model
// (word arrays plus latency arithmetic).
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] MTIME = 32'h0000_0F00;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]           sel = '0;
  logic [1:0]           we  = '0;
  logic [1:0][3:0]      byte_en = '0;
  logic [1:0][31:0]     addr = '0;
  logic [1:0][31:0]     din  = '0;
  logic [1:0][31:0]     dout;
  logic [1:0]           ack, err, ram_ce, ram_we;
  logic [1:0][3:0]      ram_be;
  logic [1:0][AW-1:0]   ram_addr;
  logic [1:0][31:0]     ram_wdata;
  logic [1:0][31:0]     ram_rdata;

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(AW), .WAIT_STATES(WS0), .MTIME_ADDR(MTIME)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel[0]), .we(we[0]), .byte_en(byte_en[0]), .addr(addr[0]),
    .din(din[0]), .dout(dout[0]), .ack(ack[0]), .err(err[0]), .ram_ce(ram_ce[0]), .ram_we(ram_we[0]),
    .ram_be(ram_be[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(AW), .WAIT_STATES(WS1), .MTIME_ADDR(MTIME)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .we(we[1]), .byte_en(byte_en[1]), .addr(addr[1]),
    .din(din[1]), .dout(dout[1]), .ack(ack[1]), .err(err[1]), .ram_ce(ram_ce[1]), .ram_we(ram_we[1]),
    .ram_be(ram_be[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

  // ---------------- behavioural SRAMs ----------------
  logic [31:0] mem [2][DEPTH];
  int          ce_cnt [2] = '{0, 0};

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_ce[g]) begin
        ce_cnt[g] = ce_cnt[g] + 1;
        if (ram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[g][b]) mem[g][ram_addr[g]][8*b +: 8] = ram_wdata[g][8*b +: 8];
        end else begin
          ram_rdata[g] <= mem[g][ram_addr[g]];
        end
      end
    end
  end

  // SRAM strobes must be quiet whenever chip enable is low.
  int quiet_viol = 0;
  always @(negedge clk) begin
    if (rst_n)
      for (int g = 0; g < 2; g++)
        if (!ram_ce[g] && (ram_we[g] || ram_be[g] != 4'b0000)) quiet_viol = quiet_viol + 1;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem  [2][DEPTH];
  logic [31:0] ref_dout [2] = '{32'h0, 32'h0};

  typedef struct {
    bit          e;
    int          lat;
    logic [31:0] rd;
    int          ces;
  } exp_t;

  typedef struct {
    int          lat;
    bit          e;
    logic [31:0] rd;
    int          ces;
    int          t0;
  } resp_t;

  function automatic bit ref_legal(logic [3:0] be, logic [31:0] a);
    bit mask_ok;
    int low;
    mask_ok = be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    low = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) low = i;
    return mask_ok && (int'(a[1:0]) == low) && (a >= BASE) && (a < BASE + 4 * DEPTH);
  endfunction

  function automatic exp_t model(int d, bit w, logic [3:0] be, logic [31:0] a, logic [31:0] wd);
    exp_t x;
    int   ws;
    int   idx;
    ws  = (d == 0) ? WS0 : WS1;
    x.e = !ref_legal(be, a);
    if (x.e) begin
      x.lat = 1;
      x.ces = 0;
    end else begin
      idx   = int'((a - BASE) / 4);
      x.ces = 1;
      if (w) begin
        x.lat = 2 + ws;
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        x.lat = 3 + ws;
        ref_dout[d] = ref_mem[d][idx];
      end
    end
    x.rd = ref_dout[d];
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input int d, input bit w, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input int at_cyc, input bit drop_early,
                        output resp_t r);
    int c0;
    @(negedge clk);
    while (cyc < at_cyc) @(negedge clk);
    c0   = ce_cnt[d];
    r.t0 = cyc;
    sel[d] = 1'b1; we[d] = w; byte_en[d] = be; addr[d] = a; din[d] = wd;
    r.lat = 0;
    do begin
      @(posedge clk); #1;
      r.lat++;
      if (drop_early) sel[d] = 1'b0;
    end while (ack[d] !== 1'b1 && r.lat < 40);
    r.e   = err[d];
    r.rd  = dout[d];
    r.ces = ce_cnt[d] - c0;
    sel[d] = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_and_check(input string tag, input int d, input bit w, input logic [3:0] be,
                               input logic [31:0] a, input logic [31:0] wd);
    exp_t  x;
    resp_t r;
    x = model(d, w, be, a, wd);
    do_req(d, w, be, a, wd, -1, 1'b0, r);
    check({tag, ".lat"},  64'(r.lat), 64'(x.lat));
    check({tag, ".err"},  64'(r.e),   64'(x.e));
    check({tag, ".ces"},  64'(r.ces), 64'(x.ces));
    check({tag, ".dout"}, 64'(r.rd),  64'(x.rd));
  endtask

  // ---------------- directed vector table (instance 0, no wait states) ----------------
  typedef struct {
    bit          w;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    bit          e;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [18];

  // Watchdog: the run must end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t       r;
    exp_t        x;
    int          bad;
    logic [3:0]  masks [10];
    logic [31:0] a;
    int          d;

    for (int g = 0; g < 2; g++)
      for (int i = 0; i < DEPTH; i++) begin
        mem[g][i]     = 32'h0;
        ref_mem[g][i] = 32'h0;
      end

    vecs[0]  = '{1'b1, 4'b1111, 32'h1004, 32'hDEAD_BEEF, 1'b0, 2, 32'h0000_0000};
    vecs[1]  = '{1'b0, 4'b1111, 32'h1004, 32'h0,         1'b0, 3, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'b1111, 32'h1004, 32'h1122_3344, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 4'b0100, 32'h1006, 32'h00AB_0000, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 4'b1111, 32'h1004, 32'h0,         1'b0, 3, 32'h11AB_3344};
    vecs[5]  = '{1'b1, 4'b1111, 32'h1002, 32'h0,         1'b1, 1, 32'h11AB_3344};
    vecs[6]  = '{1'b1, 4'b0101, 32'h1000, 32'h0,         1'b1, 1, 32'h11AB_3344};
    vecs[7]  = '{1'b0, 4'b1111, 32'h2000, 32'h0,         1'b1, 1, 32'h11AB_3344};
    vecs[8]  = '{1'b0, 4'b1111, 32'h0FFC, 32'h0,         1'b1, 1, 32'h11AB_3344};
    vecs[9]  = '{1'b1, 4'b1111, 32'h1FFC, 32'hCAFE_F00D, 1'b0, 2, 32'h11AB_3344};
    vecs[10] = '{1'b0, 4'b1111, 32'h1FFC, 32'h0,         1'b0, 3, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 4'b1100, 32'h1012, 32'hA5A5_0000, 1'b0, 2, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 4'b1000, 32'h1013, 32'h7700_0000, 1'b0, 2, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, 4'b0011, 32'h1010, 32'h0,         1'b0, 3, 32'h77A5_0000};
    vecs[14] = '{1'b0, 4'b0010, 32'h1011, 32'h0,         1'b0, 3, 32'h77A5_0000};
    vecs[15] = '{1'b0, 4'b0011, 32'h1012, 32'h0,         1'b1, 1, 32'h77A5_0000};
    vecs[16] = '{1'b0, 4'b1100, 32'h1001, 32'h0,         1'b1, 1, 32'h77A5_0000};
    vecs[17] = '{1'b1, 4'b0000, 32'h1000, 32'h0,         1'b1, 1, 32'h77A5_0000};

    masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111,
              4'b0101, 4'b0000, 4'b0110};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst.ack",       64'(ack[0]),       64'(0));
    check("rst.err",       64'(err[0]),       64'(0));
    check("rst.dout",      64'(dout[0]),      64'(0));
    check("rst.ram_ce",    64'(ram_ce[0]),    64'(0));
    check("rst.ram_we",    64'(ram_we[0]),    64'(0));
    check("rst.ram_be",    64'(ram_be[0]),    64'(0));
    check("rst.ram_addr",  64'(ram_addr[0]),  64'(0));
    check("rst.ram_wdata", 64'(ram_wdata[0]), 64'(0));
    check("rst.ack1",      64'(ack[1]),       64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // ---- table ----
    for (int i = 0; i < 18; i++) begin
      x = model(0, vecs[i].w, vecs[i].be, vecs[i].a, vecs[i].wd);
      do_req(0, vecs[i].w, vecs[i].be, vecs[i].a, vecs[i].wd, -1, 1'b0, r);
      check($sformatf("vec%0d.lat", i),  64'(r.lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d.err", i),  64'(r.e),   64'(vecs[i].e));
      check($sformatf("vec%0d.ces", i),  64'(r.ces), 64'(vecs[i].e ? 0 : 1));
      check($sformatf("vec%0d.dout", i), 64'(r.rd),  64'(vecs[i].rd));
    end

    // ---- three wait states: load latency 6, single SRAM strobe ----
    run_and_check("ws3.store", 1, 1'b1, 4'b1111, 32'h1040, 32'h0BAD_C0DE);
    x = model(1, 1'b0, 4'b1111, 32'h1040, 32'h0);
    do_req(1, 1'b0, 4'b1111, 32'h1040, 32'h0, -1, 1'b0, r);
    check("ws3.load.lat",  64'(r.lat), 64'(6));
    check("ws3.load.ces",  64'(r.ces), 64'(1));
    check("ws3.load.dout", 64'(r.rd),  64'(32'h0BAD_C0DE));
    run_and_check("ws3.err", 1, 1'b0, 4'b1111, 32'h1042, 32'h0);

    // ---- sel dropped after acceptance: transaction still completes ----
    x = model(0, 1'b0, 4'b1111, 32'h1004, 32'h0);
    do_req(0, 1'b0, 4'b1111, 32'h1004, 32'h0, -1, 1'b1, r);
    check("early_drop.lat",  64'(r.lat), 64'(x.lat));
    check("early_drop.dout", 64'(r.rd),  64'(x.rd));

    // ---- reset while waiting ----
    @(negedge clk);
    sel[1] = 1'b1; we[1] = 1'b0; byte_en[1] = 4'b1111; addr[1] = 32'h1040; din[1] = 32'h0;
    @(posedge clk); #1;
    check("rstw.pre_ack", 64'(ack[1]), 64'(0));
    rst_n = 1'b0;
    #1;
    check("rstw.ack",       64'(ack[1]),       64'(0));
    check("rstw.err",       64'(err[1]),       64'(0));
    check("rstw.dout",      64'(dout[1]),      64'(0));
    check("rstw.dout0",     64'(dout[0]),      64'(0));
    check("rstw.ram_ce",    64'(ram_ce[1]),    64'(0));
    check("rstw.ram_addr",  64'(ram_addr[1]),  64'(0));
    check("rstw.ram_wdata", 64'(ram_wdata[1]), 64'(0));
    sel[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_dout[0] = 32'h0;
    ref_dout[1] = 32'h0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack[0] || ack[1]) bad++;
    end
    check("rstw.no_ack", 64'(bad), 64'(0));
    run_and_check("rstw.after", 1, 1'b0, 4'b1111, 32'h1040, 32'h0);

    // ---- mtime window ----
`ifdef DMEM_MTIME_EN
    begin
      resp_t r2;
      do_req(0, 1'b0, 4'b1111, MTIME, 32'h0, -1, 1'b0, r);
      check("mtime.lo.lat", 64'(r.lat), 64'(1));
      check("mtime.lo.err", 64'(r.e),   64'(0));
      check("mtime.lo.ces", 64'(r.ces), 64'(0));
      do_req(0, 1'b0, 4'b1111, MTIME, 32'h0, r.t0 + 10, 1'b0, r2);
      check("mtime.delta", 64'(r2.rd - r.rd), 64'(10));
      do_req(0, 1'b0, 4'b1111, MTIME + 32'd4, 32'h0, -1, 1'b0, r);
      check("mtime.hi.dout", 64'(r.rd), 64'(0));
      check("mtime.hi.err",  64'(r.e),  64'(0));
      do_req(0, 1'b1, 4'b1111, MTIME, 32'h1, -1, 1'b0, r);
      check("mtime.store.err", 64'(r.e),   64'(1));
      check("mtime.store.lat", 64'(r.lat), 64'(1));
      do_req(0, 1'b0, 4'b1100, MTIME + 32'd2, 32'h0, -1, 1'b0, r);
      check("mtime.half.err", 64'(r.e), 64'(1));
      do_req(1, 1'b0, 4'b1111, MTIME + 32'd4, 32'h0, -1, 1'b0, r);
      check("mtime.ws3.lat", 64'(r.lat), 64'(1));
      check("mtime.ws3.ces", 64'(r.ces), 64'(0));
      ref_dout[0] = 32'h0;
      ref_dout[1] = 32'h0;
    end
`else
    run_and_check("mtime_off.lo", 0, 1'b0, 4'b1111, MTIME, 32'h0);
    run_and_check("mtime_off.hi", 1, 1'b0, 4'b1111, MTIME + 32'd4, 32'h0);
`endif

    // ---- randomized requests against the reference model ----
    for (int i = 0; i < 80; i++) begin
      d = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       a = 32'h2000 + 32'($urandom_range(0, 15));
        1:       a = 32'h0FF0 + 32'($urandom_range(0, 15));
        default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      run_and_check($sformatf("rnd%0d", i), d, 1'($urandom_range(0, 1)),
                    masks[$urandom_range(0, 9)], a, $urandom);
    end

    check("ram_quiet", 64'(quiet_viol), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's load/store port (sel/we/byte_en/addr/din/dout/ack).
- Drives a synchronous single-port SRAM macro with 1-cycle read latency.
- Inserts programmable wait states, range-checks and alignment-checks each request, and returns a one-cycle ack with read data or an error flag.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of SRAM word 0
- DEPTH, 1024, SRAM depth in 32-bit words (power of two)
- AW, 10, SRAM word-address width; must equal log2(DEPTH)
- WAIT_STATES, 0, extra idle cycles inserted before the SRAM access (0..15)
- MTIME_ADDR, 32'h0000_0F00, byte address of the mtime low word (optional feature only)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  1  request valid; held by master until ack
- we  in  1  1 = store, 0 = load; sampled with sel
- byte_en  in  4  byte lane mask, lane-positioned
- addr  in  32  byte address
- din  in  32  store data, already lane-positioned
- dout  out  32  load data word (unshifted); valid when ack=1 and we=0
- ack  out  1  one-cycle response pulse
- err  out  1  qualifies ack; 1 = request rejected, no SRAM write
- ram_ce  out  1  SRAM chip enable
- ram_we  out  1  SRAM write enable
- ram_be  out  4  SRAM byte write enables
- ram_addr  out  AW  SRAM word address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid the cycle after ram_ce with ram_we=0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack=0, err=0, dout=0, ram_ce=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0; wait counter=0.
- FSM states: IDLE, WAIT, ACCESS, READ, RESP.
- IDLE: when sel=1, latch we/byte_en/addr/din and run the legality check.
  - Illegal request → RESP with err=1.
  - Legal request, WAIT_STATES>0 → WAIT with counter=WAIT_STATES-1.
  - Legal request, WAIT_STATES=0 → ACCESS.
- Legality:
  - byte_en must be one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111.
  - addr[1:0] must match the lowest set lane: 1111 requires 00; 0011 requires 00; 1100 requires 10; a single byte lane k requires addr[1:0]=k.
  - Range: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
- WAIT: decrement the counter; at 0 → ACCESS.
- ACCESS: ram_ce=1 for exactly one cycle; ram_addr=(addr-BASE_ADDR)>>2; ram_we=we; ram_be=byte_en if store else 0; ram_wdata=din.
  - Store → RESP.
  - Load → READ.
- READ: ram_ce=0; capture ram_rdata into dout; → RESP.
- RESP: ack=1, err as computed, for one cycle; → IDLE.
- Latency sel→ack:
  - Store: 2+WAIT_STATES cycles.
  - Load: 3+WAIT_STATES cycles.
  - Error: 1 cycle.
- Handshake:
  - Master holds sel and all request fields stable until it sees ack, then drops sel in the following cycle.
  - sel=1 in IDLE is always a new request, so back-to-back requests need no gap beyond the IDLE cycle.
  - Request inputs are ignored outside IDLE; the latched copy is used.
- dout holds its last load value until the next load completes; it is not cleared by stores or errors.
- ram_ce, ram_we and ram_be are 0 in every state other than ACCESS.
- Reset mid-transaction: the SRAM access is abandoned and no ack is produced.
  - A store already in ACCESS at reset assertion may or may not have been written; this is not defined.
- sel dropped early (protocol violation): the transaction still completes and ack still pulses.

Optional Feature:
- Macro: DMEM_MTIME_EN.
- Defined:
  - 64-bit free-running counter, reset to 0, incrementing every clock.
  - Loads with byte_en=1111 to MTIME_ADDR return bits [31:0]; to MTIME_ADDR+4 return bits [63:32].
  - Served IDLE→RESP (1-cycle latency), with no wait states and no SRAM access.
  - Any store or non-word access in that 8-byte window → err=1.
- Undefined: no counter logic; the window is decoded as ordinary out-of-range (err=1 unless inside the SRAM range).

Decomposition:
- Package dmem_pkg:
  - FSM state encoding.
  - Legal byte_en constants (BE_B0..BE_B3, BE_HLO, BE_HHI, BE_W).
  - MTIME word offsets.
- Sub-module dmem_be_check: combinational legality check (byte_en, addr[1:0], range) → legal flag.

Test Plan:
- Store then load, WAIT_STATES=0:
  - Store addr=0x1004, be=1111, din=0xDEADBEEF → ack 2 cycles after sel, err=0.
  - Load at 0x1004 → ack 3 cycles after sel, dout=0xDEADBEEF.
- Byte lane write: store addr=0x1006, be=0100, din=0x00AB0000 over 0x11223344 → subsequent word load returns 0x11AB3344.
- Errors, each acked 1 cycle after sel with err=1 and ram_ce never asserted:
  - Misaligned: addr=0x1002, be=1111.
  - Illegal mask: be=0101.
  - Out of range: addr=0x2000 with DEPTH=1024.
- WAIT_STATES=3: load latency is 6 cycles; ram_ce high exactly one cycle.
- Reset asserted in WAIT → all outputs 0 immediately; no ack; the next request after reset completes normally.
- DMEM_MTIME_EN: two reads of MTIME_ADDR issued 10 cycles apart differ by 10; a store to MTIME_ADDR → err=1.
